// File: rtl/md_pkg.sv
// Shared op codes and FSM state encoding for the multiply/divide unit.
package md_pkg;

  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  // mfhi/mflo are resolved in the E-stage result mux, not inside md_unit
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_div_core.sv
// Combinational quotient/remainder, signed (truncating toward zero) or unsigned,
// with a divide-by-zero flag.
module md_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe, quo_mag, rem_mag;

  assign neg_a = is_signed & a[WIDTH-1];
  assign neg_b = is_signed & b[WIDTH-1];
  assign a_mag = neg_a ? (~a + 1'b1) : a;
  assign b_mag = neg_b ? (~b + 1'b1) : b;

  assign div_zero = (b == '0);
  // Keeps the divider defined for b=0; the result is discarded in that case.
  assign b_safe = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;

  // MIN/-1 falls out naturally: |MIN| as unsigned divided by 1 is MIN again.
  assign quo_mag = a_mag / b_safe;
  assign rem_mag = a_mag % b_safe;

  assign quo = (neg_a ^ neg_b) ? (~quo_mag + 1'b1) : quo_mag;
  assign rem = neg_a ? (~rem_mag + 1'b1) : rem_mag;

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers and a busy stall output.
// Define MD_MADD_EN to add madd/maddu (accumulate product into {hi,lo}).
//
// state | meaning
// IDLE  | accepts start (when req=0); mthi/mtlo complete here
// BUSY  | long op in flight; counter runs N..1, {hi,lo} updated on exit
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             req,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(1);

  md_state_t          state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [WIDTH-1:0]   pend_hi, pend_hi_d, pend_lo, pend_lo_d;
  logic               pend_wr, pend_wr_d;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic               accept;
  logic [2*WIDTH-1:0] prod_u, prod_s;
  logic [WIDTH-1:0]   quo, rem;
  logic               div_zero;

  // Low 2*WIDTH bits of the sign-extended product equal the signed product.
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};

  md_div_core #(.WIDTH(WIDTH)) u_div (
    .a        (a),
    .b        (b),
    .is_signed(op == MD_DIV),
    .quo      (quo),
    .rem      (rem),
    .div_zero (div_zero)
  );

  assign accept = start & ~req & (state == IDLE);
  assign busy   = (state == BUSY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      pend_hi <= pend_hi_d;
      pend_lo <= pend_lo_d;
      pend_wr <= pend_wr_d;
      hi      <= hi_d;
      lo      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pend_hi_d = pend_hi;
    pend_lo_d = pend_lo;
    pend_wr_d = pend_wr;
    hi_d      = hi;
    lo_d      = lo;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op)
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            MD_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_N;
              state_d   = BUSY;
            end
            MD_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_N;
              state_d   = BUSY;
            end
            MD_DIV, MD_DIVU: begin
              pend_hi_d = rem;
              pend_lo_d = quo;
              pend_wr_d = ~div_zero;
              cnt_d     = DIV_N;
              state_d   = BUSY;
            end
`ifdef MD_MADD_EN
            MD_MADD: begin
              {pend_hi_d, pend_lo_d} = {hi, lo} + prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_N;
              state_d   = BUSY;
            end
            MD_MADDU: begin
              {pend_hi_d, pend_lo_d} = {hi, lo} + prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_N;
              state_d   = BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt == CNT_TC) begin
          if (pend_wr) begin
            hi_d = pend_hi;
            lo_d = pend_lo;
          end
          pend_wr_d = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: each issued op pushes its expected busy length
// and final hi/lo; a monitor pops and compares once busy drops.
module tb_md_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         req = 1'b0;
  logic         busy;
  logic [W-1:0] hi, lo;

  md_unit dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .req  (req),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    int           len;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   mon_active = 1'b0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  // Monitor: triggered by each start edge, measures busy length, compares result.
  initial begin
    exp_t e;
    int   len;
    forever begin
      @(posedge clk);
      if (start) begin
        mon_active = 1'b1;
        check("no_start_while_busy", {31'b0, busy}, '0);
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL scoreboard_empty: got start with no expectation, expected one queued");
          e.name = "none"; e.len = 0; e.hi = hi; e.lo = lo;
        end else begin
          e = q.pop_front();
        end
        len = 0;
        @(negedge clk);
        while (busy && len < 50) begin
          len++;
          @(negedge clk);
        end
        check({e.name, "_len"}, W'(len), W'(e.len));
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
        mon_active = 1'b0;
      end
    end
  end

  task automatic issue(input string name, input logic [3:0] o, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic vreq, input int len,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo);
    exp_t e;
    e.name = name; e.len = len; e.hi = ehi; e.lo = elo;
    q.push_back(e);
    @(negedge clk);
    op = o; a = va; b = vb; req = vreq; start = 1'b1;
    @(negedge clk);
    start = 1'b0; req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((q.size() != 0 || mon_active) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_total++;
      $display("FAIL %s_timeout: got no completion in %0d cycles, expected completion", name, n);
    end
  endtask

  initial begin
    #12;
    check("reset_busy", {31'b0, busy}, '0);
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);
    @(negedge clk);
    reset = 1'b0;

    issue("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    wait_idle("mult_neg");
    issue("divu", 4'd4, 32'd7, 32'hFFFF_FFFE, 1'b0, 10, 32'd7, 32'd0);
    wait_idle("divu");
    issue("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_idle("div_neg");
    issue("div_zero", 4'd3, 32'd5, 32'd0, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_idle("div_zero");
    issue("mult_req", 4'd1, 32'd3, 32'd3, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_idle("mult_req");
    issue("mthi", 4'd7, 32'h1234_5678, 32'd0, 1'b0, 0, 32'h1234_5678, 32'hFFFF_FFFD);
    wait_idle("mthi");
    issue("mtlo", 4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 32'h1234_5678, 32'hFFFF_FFFF);
    wait_idle("mtlo");
    issue("mthi_req", 4'd7, 32'd0, 32'd0, 1'b1, 0, 32'h1234_5678, 32'hFFFF_FFFF);
    wait_idle("mthi_req");
    issue("undef_op", 4'd15, 32'd9, 32'd9, 1'b0, 0, 32'h1234_5678, 32'hFFFF_FFFF);
    wait_idle("undef_op");
    issue("mthi_zero", 4'd7, 32'd0, 32'd0, 1'b0, 0, 32'd0, 32'hFFFF_FFFF);
    wait_idle("mthi_zero");
`ifdef MD_MADD_EN
    issue("maddu", 4'd10, 32'd1, 32'd1, 1'b0, 5, 32'd1, 32'd0);
`else
    issue("maddu_off", 4'd10, 32'd1, 32'd1, 1'b0, 0, 32'd0, 32'hFFFF_FFFF);
`endif
    wait_idle("maddu");
    issue("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_idle("multu_max");
    issue("div_min_m1", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'd0, 32'h8000_0000);
    wait_idle("div_min_m1");

    // req toggled while busy must not disturb the in-flight divu (100/7 = 14 r 2)
    issue("divu_req_busy", 4'd4, 32'd100, 32'd7, 1'b0, 10, 32'd2, 32'd14);
    req = 1'b1;
    repeat (3) @(negedge clk);
    req = 1'b0;
    wait_idle("divu_req_busy");

    // Reset lands in the 3rd busy cycle of a mult
    issue("mult_reset", 4'd1, 32'd5, 32'd5, 1'b0, 2, 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_busy", {31'b0, busy}, '0);
    check("async_reset_hi", hi, '0);
    check("async_reset_lo", lo, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_idle("mult_reset");
    repeat (12) @(negedge clk);
    check("post_reset_busy", {31'b0, busy}, '0);
    check("post_reset_hi", hi, '0);
    check("post_reset_lo", lo, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
